mr_emi_arb: RTL and testbench
=============================

# mr_emi_arb

Two-into-one External Memory Interface (EMI) arbiter between the CPU's instruction fetch EMI port (read-only) and data EMI port (read-write), and a single downstream EMI memory slave. It grants one master per transaction and forwards that master's request fields to memory. It counts the returned beats so that a cache-line burst completes cleanly. It then enforces the mandatory req-low gap before re-arbitrating.

## Interface
- `ADDR_W`, 32: EMI address width.
- `DATA_W`, 64: EMI beat width.
- `CL_BEATS`, 4: beats per size=2'b11 (cache-line) transaction.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `i_emi_addr` in ADDR_W: instruction fetch (I) master address.
- `i_emi_size` in 2: I master size; 2'b11 = cache line.
- `i_emi_req` in 1: I master request, held for the whole transaction.
- `i_emi_rdata` out DATA_W: I read data.
- `i_emi_valid` out 1: I beat valid.
- `d_emi_addr` in ADDR_W: data (D) master address.
- `d_emi_wdata` in DATA_W: D write data.
- `d_emi_size` in 2: D master size.
- `d_emi_RnW` in 1: D read (1) / write (0).
- `d_emi_bws` in 8: D byte write strobes.
- `d_emi_req` in 1: D master request.
- `d_emi_rdata` out DATA_W: D read data.
- `d_emi_valid` out 1: D beat valid (read data present, or write beat captured).
- `m_emi_addr`, `m_emi_wdata`, `m_emi_size`, `m_emi_RnW`, `m_emi_bws`, `m_emi_req` out: downstream request fields, same widths as D.
- `m_emi_rdata` in DATA_W: downstream read data.
- `m_emi_valid` in 1: downstream beat valid.

## Operation
- States: IDLE, GNT_I, GNT_D, DRAIN. Reset (`reset`=0) forces IDLE immediately, asynchronously.
- IDLE:
  - Only `i_emi_req` high → GNT_I.
  - Only `d_emi_req` high → GNT_D.
  - Both high → round-robin. Grant the master not granted last; the last-grant bit resets to I, so D wins the first tie.
  - Neither high → stay in IDLE.
- GNT_x:
  - `m_emi_req` = granted master's req.
  - addr/size/RnW/bws/wdata follow the granted master combinationally. For I: RnW=1, bws=8'h00, wdata=0.
- Beat counter (log2(CL_BEATS)+1 bits) clears on entry to GNT_x and increments on each `m_emi_valid`.
- Expected beats: CL_BEATS if the latched size is 2'b11, otherwise 1. Size is sampled at grant.
- On `m_emi_valid` with count = expected−1 → DRAIN.
- DRAIN: `m_emi_req`=0. Stay until the granted master's req is low, then → IDLE.
- Granted master drops req in GNT_x before the last beat (abort) → IDLE next edge. `m_emi_req` falls in the same cycle because it is combinational.
- `x_emi_valid` = `m_emi_valid` && state==GNT_x. Non-granted master's valid is 0.
- Both upstream rdata ports are driven from `m_emi_rdata` unconditionally.
- A master whose req stays high across reset release is treated as a new request.

## Timing
- Reset values:
  - state=IDLE, last-grant=I, counter=0.
  - `m_emi_req`=0, `m_emi_addr`/`wdata`/`size`/`bws`=0, `m_emi_RnW`=1.
  - `i_emi_valid`=`d_emi_valid`=0.
- Arbitration latency: req seen in IDLE at edge N → `m_emi_req` high from cycle N+1.
- Valid passthrough: zero cycles, combinational.
- Minimum downstream req-low gap between transactions: 2 cycles (DRAIN + IDLE). This satisfies the memory's one-cycle-gap rule.
- Back-to-back requests from the same master with no competitor: granted again in the cycle after IDLE.
- Stalls (`m_emi_valid` low) extend GNT_x indefinitely. There is no timeout.

## Configuration
- `MR_EMI_ARB_DPRIO_EN` defined: fixed priority, D always wins ties; the last-grant bit is not implemented.
- Undefined: round-robin as above.

## Structure
- Shared package `mr_emi_pkg`:
  - size encodings, with `EMI_SIZE_CL`=2'b11;
  - `EMI_CL_BEATS`=4;
  - the arbiter state enum.
- One natural sub-module, `mr_emi_beat_ctr`: clears on grant, counts valid beats, flags the last beat given the latched size.

## Test plan
- I-only CL read at 0x100 → `m_emi_req` rises 1 cycle after `i_emi_req`; `i_emi_valid` pulses ×4 with memory[0x20..0x23]; DRAIN until `i_emi_req` falls; `d_emi_valid` stays 0.
- D single write to 0x208, bws=8'h0F, wdata=0x1122334455667788 → memory[0x41] low word = 0x55667788, upper bytes unchanged; exactly 1 `d_emi_valid`.
- I and D raise req in the same cycle after reset → D granted first. After D completes, a re-raised I is granted before a re-raised D (round-robin). With `MR_EMI_ARB_DPRIO_EN`, D is granted both times.
- CL read under random stalls on `m_emi_valid` → exactly 4 upstream valids, and `m_emi_req` holds high throughout GNT.
- Async `reset` low mid-burst after beat 2 → `m_emi_req`=0 and `i_emi_valid`=0 in the same cycle. After release with `i_emi_req` still high, a fresh 4-beat grant follows.
- D abort: `d_emi_req` dropped after 1 beat of a CL read → IDLE next edge; a pending I is granted on the following cycle.

Source files
------------

// File: rtl/mr_emi_pkg.sv
// mr_emi_pkg: shared definitions for the EMI arbiter block.
//   - EMI size encodings (EMI_SIZE_CL = cache-line burst)
//   - EMI_CL_BEATS: default beats per cache-line transaction
//   - arb_state_e: arbiter state encoding
package mr_emi_pkg;

  localparam logic [1:0] EMI_SIZE_BYTE = 2'b00;
  localparam logic [1:0] EMI_SIZE_HALF = 2'b01;
  localparam logic [1:0] EMI_SIZE_WORD = 2'b10;
  localparam logic [1:0] EMI_SIZE_CL   = 2'b11;

  localparam int EMI_CL_BEATS = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10,
    ARB_DRAIN = 2'b11
  } arb_state_e;

endpackage

// File: rtl/mr_emi_beat_ctr.sv
// mr_emi_beat_ctr: counts returned beats of the granted EMI transaction.
//   clk, reset (async, active-low)
//   clr   : grant strobe; clears the count and samples size
//   size  : requesting master's size, sampled on clr
//   beat  : a downstream beat is valid for the granted master
//   last  : this beat is the final one of the transaction (combinational)
module mr_emi_beat_ctr
  import mr_emi_pkg::*;
#(
  parameter int CL_BEATS = EMI_CL_BEATS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [1:0] size,
  input  logic       beat,
  output logic       last
);

  localparam int CW = $clog2(CL_BEATS) + 1;

  logic [CW-1:0] count_r;
  logic          cl_r;
  logic [CW-1:0] last_idx_s;

  // Beat count and latched burst type; size is only sampled at grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
      cl_r    <= 1'b0;
    end else if (clr) begin
      count_r <= '0;
      cl_r    <= (size == EMI_SIZE_CL);
    end else if (beat) begin
      count_r <= count_r + CW'(1);
      cl_r    <= cl_r;
    end else begin
      count_r <= count_r;
      cl_r    <= cl_r;
    end
  end

  // Index of the final beat: CL_BEATS-1 for a cache line, 0 otherwise.
  always_comb begin
    last_idx_s = '0;
    if (cl_r) begin
      last_idx_s = CW'(CL_BEATS - 1);
    end else begin
      last_idx_s = '0;
    end
  end

  assign last = beat && (count_r == last_idx_s);

endmodule

// File: rtl/mr_emi_arb.sv
// mr_emi_arb: two-into-one EMI arbiter (I fetch port, D data port -> memory).
// One master is granted per transaction; its request fields pass straight
// through to the memory port. Returned beats are counted so cache-line
// bursts finish cleanly, then the arbiter holds m_emi_req low until the
// owner drops its req (DRAIN) and spends one IDLE cycle before re-arbitrating.
//
// Ports:
//   clk, reset (async, active-low)
//   i_emi_*  : instruction master (read-only)      req/addr/size in, rdata/valid out
//   d_emi_*  : data master (read/write)            req/addr/wdata/size/RnW/bws in, rdata/valid out
//   m_emi_*  : downstream slave                    request fields out, rdata/valid in
//
// Configuration:
//   MR_EMI_ARB_DPRIO_EN defined -> D always wins a tie (fixed priority).
//   undefined (default)         -> round-robin on ties, D wins the first one.
module mr_emi_arb
  import mr_emi_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int CL_BEATS = EMI_CL_BEATS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_emi_addr,
  input  logic [1:0]        i_emi_size,
  input  logic              i_emi_req,
  output logic [DATA_W-1:0] i_emi_rdata,
  output logic              i_emi_valid,
  input  logic [ADDR_W-1:0] d_emi_addr,
  input  logic [DATA_W-1:0] d_emi_wdata,
  input  logic [1:0]        d_emi_size,
  input  logic              d_emi_RnW,
  input  logic [7:0]        d_emi_bws,
  input  logic              d_emi_req,
  output logic [DATA_W-1:0] d_emi_rdata,
  output logic              d_emi_valid,
  output logic [ADDR_W-1:0] m_emi_addr,
  output logic [DATA_W-1:0] m_emi_wdata,
  output logic [1:0]        m_emi_size,
  output logic              m_emi_RnW,
  output logic [7:0]        m_emi_bws,
  output logic              m_emi_req,
  input  logic [DATA_W-1:0] m_emi_rdata,
  input  logic              m_emi_valid
);

  arb_state_e state_r;
  arb_state_e state_s;
  // Owner of the current/most recent grant. DRAIN needs it to know whose
  // req to wait on; in round-robin builds it is also the last-grant bit.
  logic       owner_d_r;
  logic       pick_d_s;
  logic       take_s;
  logic       owner_req_s;
  logic       beat_s;
  logic       last_s;

  // Arbitration choice among the currently requesting masters.
  always_comb begin
    pick_d_s = 1'b0;
    if (i_emi_req && d_emi_req) begin
`ifdef MR_EMI_ARB_DPRIO_EN
      pick_d_s = 1'b1;
`else
      pick_d_s = !owner_d_r;
`endif
    end else if (d_emi_req) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end
  end

  assign owner_req_s = owner_d_r ? d_emi_req : i_emi_req;
  assign beat_s      = m_emi_valid && ((state_r == ARB_GNT_I) || (state_r == ARB_GNT_D));

  // Next-state logic; a granted master dropping req aborts straight to IDLE.
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (i_emi_req || d_emi_req) begin
          take_s  = 1'b1;
          state_s = pick_d_s ? ARB_GNT_D : ARB_GNT_I;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_GNT_I: begin
        if (!i_emi_req) begin
          state_s = ARB_IDLE;
        end else if (last_s) begin
          state_s = ARB_DRAIN;
        end else begin
          state_s = ARB_GNT_I;
        end
      end
      ARB_GNT_D: begin
        if (!d_emi_req) begin
          state_s = ARB_IDLE;
        end else if (last_s) begin
          state_s = ARB_DRAIN;
        end else begin
          state_s = ARB_GNT_D;
        end
      end
      ARB_DRAIN: begin
        if (!owner_req_s) begin
          state_s = ARB_IDLE;
        end else begin
          state_s = ARB_DRAIN;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // State and grant-owner registers; owner resets to I so D wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ARB_IDLE;
      owner_d_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (take_s) begin
        owner_d_r <= pick_d_s;
      end else begin
        owner_d_r <= owner_d_r;
      end
    end
  end

  mr_emi_beat_ctr #(
    .CL_BEATS (CL_BEATS)
  ) u_beat_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (take_s),
    .size  (pick_d_s ? d_emi_size : i_emi_size),
    .beat  (beat_s),
    .last  (last_s)
  );

  // Downstream request mux; outside a grant the port is parked at read/zero.
  always_comb begin
    m_emi_req   = 1'b0;
    m_emi_addr  = '0;
    m_emi_wdata = '0;
    m_emi_size  = 2'b00;
    m_emi_RnW   = 1'b1;
    m_emi_bws   = 8'h00;
    case (state_r)
      ARB_GNT_I: begin
        m_emi_req  = i_emi_req;
        m_emi_addr = i_emi_addr;
        m_emi_size = i_emi_size;
      end
      ARB_GNT_D: begin
        m_emi_req   = d_emi_req;
        m_emi_addr  = d_emi_addr;
        m_emi_wdata = d_emi_wdata;
        m_emi_size  = d_emi_size;
        m_emi_RnW   = d_emi_RnW;
        m_emi_bws   = d_emi_bws;
      end
      default: begin
        m_emi_req = 1'b0;
      end
    endcase
  end

  assign i_emi_rdata = m_emi_rdata;
  assign d_emi_rdata = m_emi_rdata;
  assign i_emi_valid = m_emi_valid && (state_r == ARB_GNT_I);
  assign d_emi_valid = m_emi_valid && (state_r == ARB_GNT_D);

endmodule

// File: tb/tb_mr_emi_arb.sv
// tb_mr_emi_arb: directed self-checking bench for mr_emi_arb.
// A behavioural EMI slave returns one beat per cycle (optionally with
// random stalls) from a memory whose unwritten words are init_word(index).
// Build with MR_EMI_ARB_DPRIO_EN defined to check the fixed-priority variant.
module tb_mr_emi_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_emi_addr = '0;
  logic [1:0]  i_emi_size = 2'b00;
  logic        i_emi_req = 1'b0;
  logic [63:0] i_emi_rdata;
  logic        i_emi_valid;
  logic [31:0] d_emi_addr = '0;
  logic [63:0] d_emi_wdata = '0;
  logic [1:0]  d_emi_size = 2'b00;
  logic        d_emi_RnW = 1'b1;
  logic [7:0]  d_emi_bws = 8'h00;
  logic        d_emi_req = 1'b0;
  logic [63:0] d_emi_rdata;
  logic        d_emi_valid;
  logic [31:0] m_emi_addr;
  logic [63:0] m_emi_wdata;
  logic [1:0]  m_emi_size;
  logic        m_emi_RnW;
  logic [7:0]  m_emi_bws;
  logic        m_emi_req;
  logic [63:0] m_emi_rdata = '0;
  logic        m_emi_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  mr_emi_arb dut (
    .clk(clk), .reset(reset),
    .i_emi_addr(i_emi_addr), .i_emi_size(i_emi_size), .i_emi_req(i_emi_req),
    .i_emi_rdata(i_emi_rdata), .i_emi_valid(i_emi_valid),
    .d_emi_addr(d_emi_addr), .d_emi_wdata(d_emi_wdata), .d_emi_size(d_emi_size),
    .d_emi_RnW(d_emi_RnW), .d_emi_bws(d_emi_bws), .d_emi_req(d_emi_req),
    .d_emi_rdata(d_emi_rdata), .d_emi_valid(d_emi_valid),
    .m_emi_addr(m_emi_addr), .m_emi_wdata(m_emi_wdata), .m_emi_size(m_emi_size),
    .m_emi_RnW(m_emi_RnW), .m_emi_bws(m_emi_bws), .m_emi_req(m_emi_req),
    .m_emi_rdata(m_emi_rdata), .m_emi_valid(m_emi_valid)
  );

  always #5 clk = ~clk;

  // ---------------- memory slave model ----------------
  logic [63:0]  wmem [0:255];
  logic [255:0] wflag = '0;
  logic [7:0]   sl_beat = 8'd0;
  logic [7:0]   sl_idx;
  bit           stall_en = 1'b0;

  function automatic logic [63:0] init_word(input int k);
    return {32'hDEAD_0000 | 32'(k), 32'h0000_F000 | 32'(k)};
  endfunction

  function automatic logic [63:0] bw_merge(input logic [63:0] old, input logic [63:0] wd,
                                           input logic [7:0] bws);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (bws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rd_mem(input logic [7:0] idx);
    return wflag[idx] ? wmem[idx] : init_word(int'(idx));
  endfunction

  assign sl_idx = m_emi_addr[10:3] + sl_beat;

  always @(posedge clk) begin
    if (!m_emi_req) begin
      sl_beat     <= 8'd0;
      m_emi_valid <= 1'b0;
    end else if ((sl_beat < ((m_emi_size == 2'b11) ? 8'd4 : 8'd1)) &&
                 (!stall_en || ($urandom_range(0, 1) == 1))) begin
      m_emi_valid <= 1'b1;
      m_emi_rdata <= rd_mem(sl_idx);
      if (!m_emi_RnW) begin
        wmem[sl_idx]  <= bw_merge(rd_mem(sl_idx), m_emi_wdata, m_emi_bws);
        wflag[sl_idx] <= 1'b1;
      end
      sl_beat <= sl_beat + 8'd1;
    end else begin
      m_emi_valid <= 1'b0;
    end
  end

  // ---------------- upstream beat monitors ----------------
  int          i_cnt = 0;
  int          d_cnt = 0;
  logic [63:0] i_data [0:255];

  always @(posedge clk) begin
    if (i_emi_valid) begin
      i_data[i_cnt & 255] <= i_emi_rdata;
      i_cnt <= i_cnt + 1;
    end
    if (d_emi_valid) d_cnt <= d_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_beats(input bit is_d, input int base, input int n, input string tag);
    int k;
    k = 0;
    while ((((is_d ? d_cnt : i_cnt) - base) < n) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_in_time"}, 64'(k < 200), 64'd1);
  endtask

  int base;
  int bad;
  int k;

  initial begin
    // ---- reset state ----
    cyc(2);
    chk("rst_m_req", m_emi_req, 1'b0);
    chk("rst_m_addr", m_emi_addr, 32'h0);
    chk("rst_m_wdata", m_emi_wdata, 64'h0);
    chk("rst_m_size", m_emi_size, 2'b00);
    chk("rst_m_bws", m_emi_bws, 8'h00);
    chk("rst_m_rnw", m_emi_RnW, 1'b1);
    chk("rst_valids", {i_emi_valid, d_emi_valid}, 2'b00);
    reset = 1'b1;
    cyc(2);

    // ---- I-only cache-line read at 0x100 ----
    base = i_cnt;
    k = d_cnt;
    i_emi_addr = 32'h100; i_emi_size = 2'b11; i_emi_req = 1'b1;
    #1 chk("t1_req_latency0", m_emi_req, 1'b0);
    @(negedge clk);
    chk("t1_req_granted", m_emi_req, 1'b1);
    chk("t1_addr", m_emi_addr, 32'h100);
    chk("t1_rnw_bws", {m_emi_RnW, m_emi_bws}, {1'b1, 8'h00});
    wait_beats(1'b0, base, 4, "t1_beats");
    for (int n = 0; n < 4; n++) chk($sformatf("t1_data%0d", n), i_data[(base + n) & 255], init_word(32'h20 + n));
    cyc(3);
    chk("t1_count", 64'(i_cnt - base), 64'd4);
    chk("t1_drain_req_low", m_emi_req, 1'b0);
    chk("t1_no_d_valid", 64'(d_cnt - k), 64'd0);
    i_emi_req = 1'b0;
    cyc(2);

    // ---- D single write to 0x208 ----
    base = d_cnt;
    d_emi_addr = 32'h208; d_emi_wdata = 64'h1122334455667788; d_emi_size = 2'b10;
    d_emi_RnW = 1'b0; d_emi_bws = 8'h0F; d_emi_req = 1'b1;
    @(negedge clk);
    chk("t2_fields", {m_emi_req, m_emi_RnW, m_emi_bws, m_emi_addr}, {1'b1, 1'b0, 8'h0F, 32'h208});
    chk("t2_wdata", m_emi_wdata, 64'h1122334455667788);
    wait_beats(1'b1, base, 1, "t2_beat");
    cyc(3);
    chk("t2_count", 64'(d_cnt - base), 64'd1);
    chk("t2_mem", rd_mem(8'h41), 64'hDEAD0041_55667788);
    d_emi_req = 1'b0; d_emi_RnW = 1'b1; d_emi_bws = 8'h00; d_emi_size = 2'b00;
    cyc(2);

    // ---- tie after reset: D first, then round-robin ----
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    base = d_cnt;
    i_emi_req = 1'b1; d_emi_req = 1'b1;
    @(negedge clk);
    chk("t3_first_tie", m_emi_addr, 32'h208);
    wait_beats(1'b1, base, 1, "t3_d_beat");
    i_emi_req = 1'b0; d_emi_req = 1'b0;
    cyc(2);
    i_emi_req = 1'b1; d_emi_req = 1'b1;
    @(negedge clk);
`ifdef MR_EMI_ARB_DPRIO_EN
    chk("t3_second_tie", m_emi_addr, 32'h208);
`else
    chk("t3_second_tie", m_emi_addr, 32'h100);
`endif
    i_emi_req = 1'b0; d_emi_req = 1'b0;
    cyc(3);

    // ---- CL read at 0x180 with random stalls ----
    stall_en = 1'b1;
    base = i_cnt;
    bad = 0;
    i_emi_addr = 32'h180; i_emi_req = 1'b1;
    @(negedge clk);
    k = 0;
    while (((i_cnt - base) < 4) && (k < 300)) begin
      if (!m_emi_req) bad++;
      @(negedge clk);
      k++;
    end
    chk("t4_in_time", 64'(k < 300), 64'd1);
    chk("t4_req_held", 64'(bad), 64'd0);
    for (int n = 0; n < 4; n++) chk($sformatf("t4_data%0d", n), i_data[(base + n) & 255], init_word(32'h30 + n));
    cyc(3);
    chk("t4_count", 64'(i_cnt - base), 64'd4);
    i_emi_req = 1'b0;
    stall_en = 1'b0;
    cyc(2);

    // ---- async reset mid-burst, then fresh grant ----
    base = i_cnt;
    i_emi_addr = 32'h100; i_emi_req = 1'b1;
    wait_beats(1'b0, base, 2, "t5_two_beats");
    #2 reset = 1'b0;
    #1 chk("t5_rst_req", m_emi_req, 1'b0);
    chk("t5_rst_valid", i_emi_valid, 1'b0);
    cyc(2);
    reset = 1'b1;
    base = i_cnt;
    @(negedge clk);
    chk("t5_regrant", m_emi_req, 1'b1);
    wait_beats(1'b0, base, 4, "t5_beats");
    for (int n = 0; n < 4; n++) chk($sformatf("t5_data%0d", n), i_data[(base + n) & 255], init_word(32'h20 + n));
    i_emi_req = 1'b0;
    cyc(3);

    // ---- D abort after one beat, pending I granted next ----
    base = d_cnt;
    d_emi_addr = 32'h208; d_emi_size = 2'b11; d_emi_RnW = 1'b1;
    d_emi_req = 1'b1; i_emi_req = 1'b1;
    @(negedge clk);
    chk("t6_d_granted", m_emi_addr, 32'h208);
    wait_beats(1'b1, base, 1, "t6_d_beat");
    d_emi_req = 1'b0;
    #1 chk("t6_abort_req_low", m_emi_req, 1'b0);
    @(negedge clk);
    chk("t6_idle_req_low", m_emi_req, 1'b0);
    base = i_cnt;
    @(negedge clk);
    chk("t6_i_granted", {m_emi_req, m_emi_addr}, {1'b1, 32'h100});
    wait_beats(1'b0, base, 4, "t6_i_beats");
    chk("t6_i_data0", i_data[base & 255], init_word(32'h20));
    i_emi_req = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
